// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner; fetches words over req/ready and holds them until ADVANCE.
// Optional perf counters (FETCH_COUNT/STALL_COUNT) enabled by defining IFU_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter int PC_W = 10,
  parameter int INSTR_W = 18,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic               CPU_CLOCK,
  input  logic               RESET,
  output logic               IMEM_REQ,
  output logic [PC_W-1:0]    IMEM_ADDR,
  input  logic               IMEM_READY,
  input  logic [INSTR_W-1:0] IMEM_DATA,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic               INSTR_VALID,
  output logic [PC_W-1:0]    PC,
  input  logic               ADVANCE,
  input  logic               JUMP_SIGNAL,
  input  logic [2:0]         JUMP_COND,
  input  logic [PC_W-1:0]    JUMP_TARGET,
  input  logic               ZF,
  input  logic               CF,
`ifdef IFU_PERF_CNT_EN
  output logic [15:0]        FETCH_COUNT,
  output logic [15:0]        STALL_COUNT,
`endif
  output logic               JUMP_TAKEN
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2;
  localparam logic [PC_W-1:0] ONE = 1;
  logic [1:0] state;
  logic cond_true;
  logic [PC_W-1:0] next_pc;
  assign IMEM_REQ = state == REQ;
  assign IMEM_ADDR = PC;
  always_comb begin
    cond_true = JUMP_COND == 3'b000 ? 1'b1 :
                JUMP_COND == 3'b001 ? ZF :
                JUMP_COND == 3'b010 ? !CF && !ZF :
                JUMP_COND == 3'b011 ? CF :
                JUMP_COND == 3'b100 ? !CF :
                JUMP_COND == 3'b101 ? CF || ZF : 1'b0;
    next_pc = JUMP_SIGNAL && cond_true ? JUMP_TARGET : PC + ONE;
  end
  always_ff @(posedge CPU_CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      PC <= RESET_VECTOR;
      INSTRUCTION <= '0;
      INSTR_VALID <= 1'b0;
      JUMP_TAKEN <= 1'b0;
`ifdef IFU_PERF_CNT_EN
      FETCH_COUNT <= '0;
      STALL_COUNT <= '0;
`endif
    end else begin
      JUMP_TAKEN <= 1'b0;
      if (state == REQ) begin
        if (IMEM_READY) begin
          INSTRUCTION <= IMEM_DATA;
          INSTR_VALID <= 1'b1;
          state <= HOLD;
        end
`ifdef IFU_PERF_CNT_EN
        if (IMEM_READY) FETCH_COUNT <= FETCH_COUNT + 16'd1;
        else STALL_COUNT <= STALL_COUNT + 16'd1;
`endif
      end else if (state == HOLD) begin
        if (ADVANCE) begin
          INSTR_VALID <= 1'b0;
          PC <= next_pc;
          JUMP_TAKEN <= JUMP_SIGNAL && cond_true;
          state <= REQ;
        end
      end else begin
        state <= REQ;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of fetch sequencing, jump conditions, wrap and stall/reset.
module tb_instruction_fetch_unit;
  logic clk = 0, rst = 1, req, ready = 1, valid, advance = 0, js = 0, zf = 0, cf = 0, jt;
  logic [9:0] addr, pc, tgt = '0;
  logic [17:0] data, instr;
  logic [2:0] cond = '0;
  int total = 0, bad = 0;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] fetch_count, stall_count;
`endif
  always #5 clk = ~clk;
  assign data = addr == 10'd0 ? 18'h12345 : {8'hA5, addr};
  instruction_fetch_unit dut (
    .CPU_CLOCK(clk), .RESET(rst), .IMEM_REQ(req), .IMEM_ADDR(addr), .IMEM_READY(ready),
    .IMEM_DATA(data), .INSTRUCTION(instr), .INSTR_VALID(valid), .PC(pc), .ADVANCE(advance),
    .JUMP_SIGNAL(js), .JUMP_COND(cond), .JUMP_TARGET(tgt), .ZF(zf), .CF(cf),
`ifdef IFU_PERF_CNT_EN
    .FETCH_COUNT(fetch_count), .STALL_COUNT(stall_count),
`endif
    .JUMP_TAKEN(jt));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic adv(input logic j, input logic [2:0] c, input logic z, input logic f, input logic [9:0] t);
    js = j; cond = c; zf = z; cf = f; tgt = t; advance = 1;
    step();
    advance = 0; js = 0;
  endtask
  task automatic wait_hold();
    for (int i = 0; i < 20 && !valid; i++) step();
    chk("hold_timeout", valid, 1);
  endtask
  task automatic goto(input logic [9:0] p);
    adv(1, 3'b000, 0, 0, p);
    wait_hold();
  endtask
  // taken mask per JUMP_COND, bit index = {ZF,CF}
  logic [3:0] mask [8] = '{4'b1111, 4'b1100, 4'b0001, 4'b1010, 4'b0101, 4'b1110, 4'b0000, 4'b0000};
  initial begin
    step(); step();
    chk("rst_req", req, 0); chk("rst_valid", valid, 0); chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0); chk("rst_jt", jt, 0);
    rst = 0;
    step();
    chk("req_first", req, 1); chk("addr0", addr, 0); chk("valid_early", valid, 0);
    step();
    chk("valid_first", valid, 1); chk("instr0", instr, 18'h12345); chk("req_hold", req, 0); chk("jt_seq0", jt, 0);
    adv(0, 3'b000, 0, 0, 0);
    chk("addr1", addr, 1); chk("req1", req, 1); chk("jt_seq1", jt, 0); chk("valid_clr", valid, 0);
    step();
    chk("instr1", instr, {8'hA5, 10'd1});
    adv(0, 3'b000, 0, 0, 0);
    chk("addr2", addr, 2);
    wait_hold();
    js = 1;
    repeat (3) step();
    chk("js_noadv_pc", pc, 2); chk("js_noadv_valid", valid, 1); chk("js_noadv_jt", jt, 0); chk("hold_req", req, 0);
    js = 0;
    goto(10'd5);
    adv(1, 3'b001, 1, 0, 10'h200);
    chk("je_taken_addr", addr, 10'h200); chk("je_taken_jt", jt, 1);
    step();
    chk("jt_pulse_end", jt, 0);
    wait_hold();
    goto(10'd5);
    adv(1, 3'b001, 0, 0, 10'h200);
    chk("je_not_addr", addr, 10'd6); chk("je_not_jt", jt, 0);
    wait_hold();
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 4; f++) begin
        goto(10'd5);
        adv(1, 3'(c), f[1], f[0], 10'h200);
        chk($sformatf("sweep_pc_c%0d_f%0d", c, f), pc, mask[c][f] ? 10'h200 : 10'd6);
        chk($sformatf("sweep_jt_c%0d_f%0d", c, f), jt, mask[c][f]);
        wait_hold();
      end
    goto(10'h3FF);
    adv(0, 3'b000, 0, 0, 0);
    chk("wrap_addr", addr, 0); chk("wrap_req", req, 1);
    wait_hold();
    goto(10'd5);
    adv(1, 3'b000, 0, 0, 10'd5);
    chk("self_jump_pc", pc, 5); chk("self_jump_jt", jt, 1); chk("self_jump_req", req, 1);
    wait_hold();
    ready = 0;
    adv(0, 3'b000, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall_req%0d", i), req, 1);
      chk($sformatf("stall_addr%0d", i), addr, 6);
      chk($sformatf("stall_valid%0d", i), valid, 0);
      if (i < 3) step();
    end
    rst = 1; ready = 1;
    step();
    chk("abort_req", req, 0); chk("abort_pc", pc, 0); chk("abort_valid", valid, 0); chk("abort_instr", instr, 0);
`ifdef IFU_PERF_CNT_EN
    ready = 0;
    step();
    chk("cnt_rst_fetch", fetch_count, 0); chk("cnt_rst_stall", stall_count, 0);
    rst = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      step(); step();
      ready = 1;
      step();
      ready = 0;
      if (i < 2) adv(0, 3'b000, 0, 0, 0);
    end
    chk("fetch_count", fetch_count, 3); chk("stall_count", stall_count, 6);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the control unit: owns the program counter, fetches 18-bit instruction words from instruction memory over a req/ready handshake, and holds each word stable on INSTRUCTION until the control unit advances.
- On advance, the next PC is either PC+1 or a jump target. The target is taken when JUMP_SIGNAL is high and the flag condition selected by JUMP_COND holds against ZF/CF.

Parameters:
PC_W, 10, program counter / instruction address width
INSTR_W, 18, instruction word width
RESET_VECTOR, 0, PC value loaded on reset (PC_W bits)

Ports:
CPU_CLOCK  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
IMEM_REQ  output  1  fetch request to instruction memory
IMEM_ADDR  output  PC_W  fetch address; equals PC while IMEM_REQ=1
IMEM_READY  input  1  memory accepts request and IMEM_DATA is valid this cycle
IMEM_DATA  input  INSTR_W  fetched word, sampled when IMEM_REQ&IMEM_READY
INSTRUCTION  output  INSTR_W  instruction register, feeds control unit INPUT
INSTR_VALID  output  1  INSTRUCTION holds a fetched, unconsumed word
PC  output  PC_W  address of the word in INSTRUCTION / being fetched
ADVANCE  input  1  single-cycle pulse from control unit: instruction retired
JUMP_SIGNAL  input  1  current instruction is a jump
JUMP_COND  input  3  000 jmp, 001 je, 010 ja, 011 jb, 100 jae, 101 jbe, 11x never
JUMP_TARGET  input  PC_W  absolute jump destination
ZF  input  1  zero flag from compare
CF  input  1  carry flag from compare
JUMP_TAKEN  output  1  one-cycle pulse: redirect applied this cycle

Behaviour:
- Reset (RESET=1 at edge, dominates all inputs):
  - PC=RESET_VECTOR, INSTRUCTION=0, INSTR_VALID=0, IMEM_REQ=0, JUMP_TAKEN=0, state=IDLE.
  - An outstanding request is abandoned, with no capture.
- FSM states IDLE, REQ, HOLD:
  - IDLE: one cycle after reset deassert -> REQ.
  - REQ: IMEM_REQ=1, IMEM_ADDR=PC. Hold the request, with IMEM_ADDR stable, until IMEM_READY=1. On that edge: INSTRUCTION<=IMEM_DATA, INSTR_VALID<=1 -> HOLD. Latency from entering REQ is 1 cycle at best when memory returns ready immediately.
  - HOLD: IMEM_REQ=0, INSTRUCTION and PC stable. On ADVANCE=1: INSTR_VALID<=0, PC<=next_pc -> REQ. Without ADVANCE, HOLD persists indefinitely.
- Jump condition cond_true:
  - jmp: 1
  - je: ZF
  - ja: !CF & !ZF
  - jb: CF
  - jae: !CF
  - jbe: CF | ZF
  - 11x: 0
- next_pc: JUMP_TARGET if JUMP_SIGNAL & cond_true, else PC+1 modulo 2^PC_W (all-ones wraps to 0).
- JUMP_TAKEN is a registered output. It is 1 for exactly the cycle after the redirecting ADVANCE edge, otherwise 0.
- ADVANCE, JUMP_SIGNAL and JUMP_COND are ignored outside HOLD. ZF/CF are sampled only on the ADVANCE edge.
- JUMP_SIGNAL without ADVANCE has no effect.
- A jump to the current PC is legal: the same address is refetched.
- IMEM_READY while IMEM_REQ=0 is ignored.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined: adds outputs FETCH_COUNT[15:0] and STALL_COUNT[15:0], both reset to 0.
  - FETCH_COUNT increments on each captured word.
  - STALL_COUNT increments each cycle in REQ with IMEM_READY=0.
  - Both wrap at 0xFFFF->0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then IMEM_READY tied 1, IMEM_DATA=0x12345 at address 0, ADVANCE pulsed once per HOLD -> IMEM_ADDR sequence 0,1,2; INSTRUCTION=0x12345 valid 2 cycles after reset release; JUMP_TAKEN stays 0.
- In HOLD at PC=5: JUMP_SIGNAL=1, JUMP_COND=001, ZF=1, JUMP_TARGET=0x200, ADVANCE=1 -> next IMEM_ADDR=0x200, JUMP_TAKEN=1 for one cycle. Repeat with ZF=0 -> IMEM_ADDR=6, JUMP_TAKEN=0.
- Condition sweep at PC=5, ADVANCE=1, JUMP_TARGET=0x200, all ZF/CF combinations -> correct target/PC+1 per table:
  - ja taken only at ZF=0,CF=0.
  - jbe taken unless ZF=0,CF=0.
  - JUMP_COND=110 never taken.
- PC=0x3FF, ADVANCE without jump -> IMEM_ADDR=0x000.
- IMEM_READY held 0 for 4 cycles in REQ -> IMEM_REQ=1 and IMEM_ADDR stable all 4 cycles, INSTR_VALID=0. Assert RESET in cycle 3 -> next cycle IMEM_REQ=0, PC=RESET_VECTOR, no capture.
- With IFU_PERF_CNT_EN: 3 fetches with 2 stall cycles each -> FETCH_COUNT=3, STALL_COUNT=6.
